// File: rtl/dim_sched.sv
// dim_sched: round-robin scheduler sharing one dimension-offset datapath
// (width term = 100 + dx, height term = 200 + dy, result = their sum)
// among NREQ requesters. Each transaction goes IDLE (grant) -> CALC -> RESP.
//
// Ports:
//   clock        rising-edge clock
//   rst_n        synchronous active-low reset
//   req_valid    per-requester request valid
//   req_dx       flattened dx, requester i at [i*WIDTH +: WIDTH]
//   req_dy       flattened dy, requester i at [i*HEIGHT +: HEIGHT]
//   req_ready    one-hot grant, combinational, only in IDLE
//   resp_valid   result available
//   resp_id      requester index owning the result
//   resp_sum     width term + height term, zero-extended to SUMW
//   resp_ready   consumer accepts the result
//   stat_grants  saturating grant counter (DIM_SCHED_STATS_EN only)
//   stat_stalls  saturating RESP-stall counter (DIM_SCHED_STATS_EN only)
//
// Optional feature macro: DIM_SCHED_STATS_EN adds the two statistics ports.
module dim_sched #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int NREQ   = 4,
    localparam int SUMW  = ((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WIDTH-1:0]  req_dx,
    input  logic [NREQ*HEIGHT-1:0] req_dy,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    output logic [IDW-1:0]         resp_id,
    output logic [SUMW-1:0]        resp_sum,
    input  logic                   resp_ready
`ifdef DIM_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_grants,
    output logic [15:0]            stat_stalls
`endif
);

    // One extra bit so rr_ptr + offset can exceed NREQ before wrapping.
    localparam int CW = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [IDW-1:0]    rr_ptr_r;
    logic [IDW-1:0]    grant_idx_s;
    logic              grant_found_s;
    logic              grant_hit_s;
    logic              grant_s;
    logic [CW-1:0]     cand_s;
    logic [WIDTH-1:0]  sel_dx_s;
    logic [HEIGHT-1:0] sel_dy_s;
    logic [WIDTH-1:0]  dx_r;
    logic [HEIGHT-1:0] dy_r;
    logic [IDW-1:0]    id_r;
    logic [WIDTH-1:0]  w_s;
    logic [HEIGHT-1:0] h_s;
    logic [SUMW-1:0]   sum_s;

    // Saturating 16-bit increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_hit_s   = 1'b0;
        cand_s        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s        = CW'(rr_ptr_r) + CW'(k);
            cand_s        = (cand_s >= CW'(NREQ)) ? (cand_s - CW'(NREQ)) : cand_s;
            grant_hit_s   = !grant_found_s && req_valid[cand_s[IDW-1:0]];
            grant_idx_s   = grant_hit_s ? cand_s[IDW-1:0] : grant_idx_s;
            grant_found_s = grant_found_s | grant_hit_s;
        end
    end

    // A grant only happens in IDLE and never while reset is asserted.
    assign grant_s = (state_r == ST_IDLE) && grant_found_s && rst_n;

    // Select the granted requester's operands from the flattened buses.
    always_comb begin
        sel_dx_s = '0;
        sel_dy_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_dx_s = (IDW'(i) == grant_idx_s) ? req_dx[i*WIDTH +: WIDTH]   : sel_dx_s;
            sel_dy_s = (IDW'(i) == grant_idx_s) ? req_dy[i*HEIGHT +: HEIGHT] : sel_dy_s;
        end
    end

    // One-hot accept strobe, combinational in the grant cycle.
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic for the IDLE/CALC/RESP sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: state_next_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the granted request and advance the round-robin pointer.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            id_r     <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= (grant_idx_s == IDW'(NREQ - 1)) ? '0 : (grant_idx_s + IDW'(32'd1));
            dx_r     <= sel_dx_s;
            dy_r     <= sel_dy_s;
            id_r     <= grant_idx_s;
        end
    end

    // Offset datapath: each term wraps in its own width, the sum cannot overflow SUMW.
    always_comb begin
        w_s   = dx_r + WIDTH'(32'd100);
        h_s   = dy_r + HEIGHT'(32'd200);
        sum_s = SUMW'(w_s) + SUMW'(h_s);
    end

    // Response registers: loaded leaving CALC, valid dropped on consumer accept.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sum   <= '0;
        end else if (state_r == ST_CALC) begin
            resp_valid <= 1'b1;
            resp_id    <= id_r;
            resp_sum   <= sum_s;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef DIM_SCHED_STATS_EN
    // Saturating grant and stall counters.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            stat_grants <= 16'd0;
            stat_stalls <= 16'd0;
        end else begin
            if (grant_s) begin
                stat_grants <= sat_inc16(stat_grants);
            end
            if ((state_r == ST_RESP) && !resp_ready) begin
                stat_stalls <= sat_inc16(stat_stalls);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dim_sched.sv
// Self-checking bench for dim_sched (WIDTH=HEIGHT=8, NREQ=4): a per-cycle
// vector table covering single request, wrap, backpressure and mid-operation
// reset, followed by a hand-written continuous round-robin sequence.
module tb_dim_sched;

    logic        clock;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_dx;
    logic [31:0] req_dy;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [8:0]  resp_sum;
    logic        resp_ready;
`ifdef DIM_SCHED_STATS_EN
    logic [15:0] stat_grants;
    logic [15:0] stat_stalls;
`endif

    int n_vec;
    int n_err;

    dim_sched #(.WIDTH(8), .HEIGHT(8), .NREQ(4)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dx     (req_dx),
        .req_dy     (req_dy),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_ready (resp_ready)
`ifdef DIM_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] dx;
        logic [31:0] dy;
        logic        rrdy;
        logic [3:0]  e_rdy;
        logic        e_rv;
        logic [1:0]  e_id;
        logic [8:0]  e_sum;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected results of the round-robin sequence, indexed by requester.
    int exp_sum [4];
    int ng;
    int nr;
    int last_grant_cyc;
    int gidx;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_dx = 32'd0;
        req_dy = 32'd0;
        resp_ready = 1'b1;

        //          rst   valid    dx            dy            rrdy  e_rdy    e_rv  e_id  e_sum
        vt[0]  = '{1'b0, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd0};
        vt[1]  = '{1'b1, 4'b0001, 32'h00000001, 32'h00000002, 1'b1, 4'b0001, 1'b0, 2'd0, 9'd0};
        vt[2]  = '{1'b1, 4'b0000, 32'h00000037, 32'h00000037, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd0};
        vt[3]  = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd0, 9'd303};
        vt[4]  = '{1'b1, 4'b0100, 32'h00C80000, 32'h00640000, 1'b1, 4'b0100, 1'b0, 2'd0, 9'd303};
        vt[5]  = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd303};
        vt[6]  = '{1'b1, 4'b1111, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 2'd2, 9'd88};
        for (int k = 7; k <= 10; k++) vt[k] = vt[6];
        vt[11] = '{1'b1, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd2, 9'd88};
        vt[12] = '{1'b1, 4'b1111, 32'h0A000000, 32'h14000000, 1'b1, 4'b1000, 1'b0, 2'd2, 9'd88};
        vt[13] = '{1'b0, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 9'd88};
        vt[14] = '{1'b1, 4'b1111, 32'h00000001, 32'h00000002, 1'b1, 4'b0001, 1'b0, 2'd0, 9'd0};
        vt[15] = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd0};
        vt[16] = '{1'b1, 4'b1111, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd0, 9'd303};
        vt[17] = '{1'b1, 4'b1010, 32'h0000FF00, 32'h0000FF00, 1'b1, 4'b0010, 1'b0, 2'd0, 9'd303};
        vt[18] = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd303};
        vt[19] = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 2'd1, 9'd298};
        vt[20] = '{1'b0, 4'b1111, 32'h00000000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 2'd1, 9'd298};
        vt[21] = '{1'b1, 4'b1010, 32'h0000FF00, 32'h0000FF00, 1'b1, 4'b0010, 1'b0, 2'd0, 9'd0};
        vt[22] = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd0};
        vt[23] = '{1'b1, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 2'd1, 9'd298};

        repeat (2) @(posedge clock);

        // Table: one vector per cycle, outputs sampled mid-cycle.
        for (int i = 0; i < 24; i++) begin
            tick();
            rst_n      = vt[i].rst;
            req_valid  = vt[i].valid;
            req_dx     = vt[i].dx;
            req_dy     = vt[i].dy;
            resp_ready = vt[i].rrdy;
            #4;
            chk($sformatf("v%0d.req_ready", i),  32'(req_ready),  32'(vt[i].e_rdy));
            chk($sformatf("v%0d.resp_valid", i), 32'(resp_valid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d.resp_id", i),    32'(resp_id),    32'(vt[i].e_id));
            chk($sformatf("v%0d.resp_sum", i),   32'(resp_sum),   32'(vt[i].e_sum));
`ifdef DIM_SCHED_STATS_EN
            if (i == 0) begin
                chk("v0.stat_grants", 32'(stat_grants), 32'd0);
                chk("v0.stat_stalls", 32'(stat_stalls), 32'd0);
            end
            if (i == 11) begin
                chk("v11.stat_grants", 32'(stat_grants), 32'd2);
                chk("v11.stat_stalls", 32'(stat_stalls), 32'd5);
            end
`endif
        end

        // Continuous round-robin: all four valid, consumer always ready.
        // dx = {156,10,0,155}, dy = {200,20,0,55} for requesters {3,2,1,0}.
        exp_sum[0] = 510;
        exp_sum[1] = 300;
        exp_sum[2] = 330;
        exp_sum[3] = 144;
        tick();
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_dx    = {8'd156, 8'd10, 8'd0, 8'd155};
        req_dy    = {8'd200, 8'd20, 8'd0, 8'd55};
        ng = 0;
        nr = 0;
        last_grant_cyc = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #4;
            if ((req_ready != 4'b0000) && (ng < 5)) begin
                chk($sformatf("rr.grant%0d", ng), 32'(req_ready), 32'(4'b0001 << (ng % 4)));
                if (ng > 0) begin
                    chk($sformatf("rr.spacing%0d", ng), 32'(cyc - last_grant_cyc), 32'd3);
                end
                last_grant_cyc = cyc;
                ng++;
            end
            if (resp_valid && (nr < 5)) begin
                gidx = nr % 4;
                chk($sformatf("rr.resp_id%0d", nr),  32'(resp_id),  32'(gidx));
                chk($sformatf("rr.resp_sum%0d", nr), 32'(resp_sum), 32'(exp_sum[gidx]));
                nr++;
            end
            if ((ng >= 5) && (nr >= 5)) break;
            tick();
        end
        chk("rr.grant_count", 32'(ng), 32'd5);
        chk("rr.resp_count",  32'(nr), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
